ula_seq_multibyte: RTL and testbench
====================================

# ula_seq_multibyte

Multi-cycle sequencer that runs N_BYTES-wide operations through a single `ula_8_bits` slice, one byte per clock, least-significant byte first. It chains each slice's carry-out into the next slice's carry-in. It also accumulates the equality flag and reports final carry and signed overflow from the most-significant byte. It sits between a command source (start/operands) and the shared 8-bit ALU, so wide arithmetic does not need N cascaded ALU instances.

## Interface
Parameters:
- `N_BYTES`, default 4: operand width in bytes. Must be ≥ 2.

Ports:
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: command request. Sampled only when `busy`=0.
- `a`, input, 8*N_BYTES: operand A. Sampled when start is accepted.
- `b`, input, 8*N_BYTES: operand B. Sampled when start is accepted.
- `s`, input, 4: ALU function select. Sampled when start is accepted.
- `m`, input, 1: ALU mode (0 = arithmetic, 1 = logic). Sampled when start is accepted.
- `c_in`, input, 1: carry into byte 0. Sampled when start is accepted.
- `busy`, output, 1: high while the state is not IDLE.
- `done`, output, 1: one-cycle pulse marking valid results.
- `f`, output, 8*N_BYTES: result.
- `c_out`, output, 1: carry out of the most-significant byte.
- `overflow`, output, 1: overflow flag of the most-significant byte.
- `a_eq_b`, output, 1: AND of the `a_eq_b` flags from all bytes.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when `start`=1. On this edge:
  - latch `a`, `b`, `s`, `m`, `c_in` into operand registers;
  - set `idx` to 0;
  - set the carry register to `c_in`;
  - set `eq_acc` to 1.
- RUN, every cycle:
  - the ALU sees byte `idx` of the latched A and B, the latched `s`/`m`, and the carry register as `c_in`;
  - on the edge: write `f[8*idx +: 8]` from the ALU `f`, load the carry register from the ALU `c_out`, and set `eq_acc &= ALU a_eq_b`.
- At the end of RUN: when `idx` = N_BYTES-1, also capture ALU `c_out` → `c_out` and ALU `overflow` → `overflow`, then go to DONE. Otherwise `idx` increments.
- DONE: `done`=1 for exactly this cycle; then go to IDLE.
- Carry polarity is passed through unchanged, using the ALU's own convention. In logic mode (`m`=1) the carry still chains, but the ALU ignores it.
- `f`, `c_out`, `overflow`, `a_eq_b` hold their values from DONE until the next accepted start. Those registers are only overwritten during RUN.
- Output `a_eq_b` is driven from `eq_acc`. It is meaningful only at or after `done`.
- `idx` is $clog2(N_BYTES) bits wide. It never wraps past N_BYTES-1.

## Timing
- Start accepted on edge 0 → RUN covers cycles 1..N_BYTES → `done` is high in cycle N_BYTES+1.
- Latency from start to done is N_BYTES+1 cycles: 5 for the default. Throughput is one operation per N_BYTES+2 cycles.
- `start` while `busy`=1 (RUN or DONE) is ignored. It is neither queued nor latched, and the operand registers are unchanged.
- `start` in the cycle after DONE (back in IDLE) is accepted normally.
- Reset values: `busy`=0, `done`=0, `f`=0, `c_out`=0, `overflow`=0, `a_eq_b`=0; state IDLE, `idx`=0.
- Reset mid-operation:
  - `rst` wins over everything; FSM goes to IDLE on that edge;
  - no `done` pulse is issued for the aborted operation;
  - all outputs return to their reset values.
- `start` with `rst` asserted in the same cycle is ignored.

## Structure
- Shared package `ula_pkg`:
  - state enum `seq_state_t` {IDLE, RUN, DONE};
  - function-select constants `ULA_ADD` = 4'b0101 and `ULA_SUB` = 4'b1000.
- Exactly one `ula_8_bits` sub-module instance, combinational, driven from the operand byte muxes.
- No other sub-modules. The byte select is an indexed part-select on the latched operands.

## Test plan
- **Reset:** hold `rst` for 2 cycles → `busy`=0, `done`=0, `f`=0, all flags 0.
- **Add, byte carry:** `s`=0101, `m`=0, `c_in`=0, A=0x000000FF, B=0x00000001. Start at cycle 0 → `done` only in cycle 5 with `f`=0x00000100, `c_out`=0, `overflow`=0. `busy` is high in cycles 1..5.
- **Add, overflow and carry:**
  - A=0x7FFFFFFF + B=0x00000001 → `f`=0x80000000, `overflow`=1;
  - A=0xFFFFFFFF + B=0x00000001 → `f`=0x00000000, `c_out` matches the 8-bit ALU's carry for FF+01.
- **Subtract:** `s`=1000, A=0x0000000A, B=0x00000005 → `f`=0x00000005. Swapped operands → `f`=0xFFFFFFFB.
- **Compare:**
  - A=B=0x55AA55AA → `a_eq_b`=1 at `done`;
  - A=0xD5AA55AA, B=0x55AA55AA → `a_eq_b`=0, since only the top byte differs.
- **Abort and ignored start:**
  - `start` pulsed during RUN with different operands → result unchanged, only one `done`;
  - `rst` asserted in cycle 3 → no `done`, outputs return to 0;
  - a fresh start after reset completes correctly.

Source files
------------

// File: rtl/ula_seq_multibyte_pkg.sv
// Shared types and function-select codes for the byte-serial ALU sequencer.
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    localparam logic [3:0] ULA_ADD = 4'b0101;
    localparam logic [3:0] ULA_SUB = 4'b1000;

endpackage

// File: rtl/ula_seq_multibyte_if.sv
// Command/result bundle between a command source and the multibyte sequencer.
interface ula_seq_multibyte_if #(
    parameter int unsigned N_BYTES = 4
);
    logic                   start;
    logic [8*N_BYTES-1:0]   a;
    logic [8*N_BYTES-1:0]   b;
    logic [3:0]             s;
    logic                   m;
    logic                   c_in;
    logic                   busy;
    logic                   done;
    logic [8*N_BYTES-1:0]   f;
    logic                   c_out;
    logic                   overflow;
    logic                   a_eq_b;

    modport master (
        output start, a, b, s, m, c_in,
        input  busy, done, f, c_out, overflow, a_eq_b
    );

    modport slave (
        input  start, a, b, s, m, c_in,
        output busy, done, f, c_out, overflow, a_eq_b
    );
endinterface

// File: rtl/ula_seq_multibyte_alu.sv
// Combinational 8-bit ALU slice. Carry is active-high; in SUB it acts as borrow in/out.
module ula_8_bits
    import ula_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [3:0] i_s,
    input  logic       i_m,
    input  logic       i_c_in,
    output logic [7:0] o_f,
    output logic       o_c_out,
    output logic       o_overflow,
    output logic       o_a_eq_b
);
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [8:0] w_inc;

    assign w_sum    = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_c_in};
    assign w_diff   = {1'b0, i_a} - {1'b0, i_b} - {8'd0, i_c_in};
    assign w_inc    = {1'b0, i_a} + {8'd0, i_c_in};
    assign o_a_eq_b = (i_a == i_b);

    always_comb begin
        o_f        = i_a;
        o_c_out    = 1'b0;
        o_overflow = 1'b0;
        if (i_m) begin
            case (i_s[1:0])
                2'b00:   o_f = ~i_a;
                2'b01:   o_f = i_a & i_b;
                2'b10:   o_f = i_a | i_b;
                default: o_f = i_a ^ i_b;
            endcase
        end else begin
            case (i_s)
                ULA_ADD: begin
                    o_f        = w_sum[7:0];
                    o_c_out    = w_sum[8];
                    o_overflow = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
                end
                ULA_SUB: begin
                    o_f        = w_diff[7:0];
                    o_c_out    = w_diff[8];
                    o_overflow = (i_a[7] != i_b[7]) && (w_diff[7] != i_a[7]);
                end
                default: begin
                    o_f        = w_inc[7:0];
                    o_c_out    = w_inc[8];
                    o_overflow = ~i_a[7] & w_inc[7];
                end
            endcase
        end
    end
endmodule

// File: rtl/ula_seq_multibyte.sv
// Runs N_BYTES-wide operations through one 8-bit ALU slice, LSB first, chaining carry.
module ula_seq_multibyte
    import ula_pkg::*;
#(
    parameter int unsigned N_BYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    ula_seq_multibyte_if.slave  bus
);
    localparam int unsigned     W        = 8 * N_BYTES;
    localparam int unsigned     IDX_W    = $clog2(N_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_d;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [3:0]       r_s;
    logic             r_m;
    logic             r_carry;
    logic             r_eq_acc;
    logic [W-1:0]     r_f;
    logic             r_c_out;
    logic             r_overflow;

    logic [7:0]       w_alu_f;
    logic             w_alu_c_out;
    logic             w_alu_overflow;
    logic             w_alu_eq;

    ula_8_bits u_alu (
        .i_a        (r_a[8*r_idx +: 8]),
        .i_b        (r_b[8*r_idx +: 8]),
        .i_s        (r_s),
        .i_m        (r_m),
        .i_c_in     (r_carry),
        .o_f        (w_alu_f),
        .o_c_out    (w_alu_c_out),
        .o_overflow (w_alu_overflow),
        .o_a_eq_b   (w_alu_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_state_d = RUN;
            RUN:     if (r_idx == LAST_IDX) w_state_d = DONE;
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Results persist after DONE; only RUN cycles overwrite them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_s        <= '0;
            r_m        <= 1'b0;
            r_carry    <= 1'b0;
            r_eq_acc   <= 1'b0;
            r_f        <= '0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == IDLE && bus.start) begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_s      <= bus.s;
                r_m      <= bus.m;
                r_carry  <= bus.c_in;
                r_idx    <= '0;
                r_eq_acc <= 1'b1;
            end
            if (r_state == RUN) begin
                r_f[8*r_idx +: 8] <= w_alu_f;
                r_carry           <= w_alu_c_out;
                r_eq_acc          <= r_eq_acc & w_alu_eq;
                if (r_idx == LAST_IDX) begin
                    r_c_out    <= w_alu_c_out;
                    r_overflow <= w_alu_overflow;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);
    assign bus.f        = r_f;
    assign bus.c_out    = r_c_out;
    assign bus.overflow = r_overflow;
    assign bus.a_eq_b   = r_eq_acc;
endmodule

// File: tb/tb_ula_seq_multibyte.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor checks each done pulse.
module tb_ula_seq_multibyte;
    import ula_pkg::*;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    typedef struct packed {
        logic [W-1:0] f;
        logic         c;
        logic         v;
        logic         e;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ula_seq_multibyte_if #(.N_BYTES(NB)) bus ();

    ula_seq_multibyte #(.N_BYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no done at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_f", bus.f, e.f);
                check("result_c_out", W'(bus.c_out), W'(e.c));
                check("result_overflow", W'(bus.overflow), W'(e.v));
                check("result_a_eq_b", W'(bus.a_eq_b), W'(e.e));
            end
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                         input logic m, input logic c);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.s     = s;
        bus.m     = m;
        bus.c_in  = c;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.busy !== 1'b0) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL %s_timeout: got pending=%0d want 0", name, sb_q.size());
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic m, input logic c, input exp_t e);
        @(negedge clk);
        drive(a, b, s, m, c);
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(name);
        @(negedge clk);
        check({name, "_hold_f"}, bus.f, e.f);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.s     = '0;
        bus.m     = 1'b0;
        bus.c_in  = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", W'(bus.busy), '0);
        check("rst_done", W'(bus.done), '0);
        check("rst_f", bus.f, '0);
        check("rst_flags", W'({bus.c_out, bus.overflow, bus.a_eq_b}), '0);
        rst = 1'b0;

        // Add with byte carry, plus cycle-accurate busy/done timing
        @(negedge clk);
        drive(32'h0000_00FF, 32'h0000_0001, ULA_ADD, 1'b0, 1'b0);
        sb_q.push_back(exp_t'{f: 32'h0000_0100, c: 1'b0, v: 1'b0, e: 1'b0});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check($sformatf("busy_cyc%0d", k), W'(bus.busy), W'(k <= 5));
            check($sformatf("done_cyc%0d", k), W'(bus.done), W'(k == 5));
        end
        wait_idle("add_carry");

        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, ULA_ADD, 1'b0, 1'b0,
               exp_t'{f: 32'h8000_0000, c: 1'b0, v: 1'b1, e: 1'b0});
        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, ULA_ADD, 1'b0, 1'b0,
               exp_t'{f: 32'h0000_0000, c: 1'b1, v: 1'b0, e: 1'b0});
        run_op("add_cin", 32'h0000_0010, 32'h0000_0020, ULA_ADD, 1'b0, 1'b1,
               exp_t'{f: 32'h0000_0031, c: 1'b0, v: 1'b0, e: 1'b0});
        run_op("sub", 32'h0000_000A, 32'h0000_0005, ULA_SUB, 1'b0, 1'b0,
               exp_t'{f: 32'h0000_0005, c: 1'b0, v: 1'b0, e: 1'b0});
        run_op("sub_swap", 32'h0000_0005, 32'h0000_000A, ULA_SUB, 1'b0, 1'b0,
               exp_t'{f: 32'hFFFF_FFFB, c: 1'b1, v: 1'b0, e: 1'b0});
        run_op("cmp_eq", 32'h55AA_55AA, 32'h55AA_55AA, ULA_SUB, 1'b0, 1'b0,
               exp_t'{f: 32'h0000_0000, c: 1'b0, v: 1'b0, e: 1'b1});
        run_op("cmp_ne", 32'hD5AA_55AA, 32'h55AA_55AA, ULA_SUB, 1'b0, 1'b0,
               exp_t'{f: 32'h8000_0000, c: 1'b0, v: 1'b0, e: 1'b0});
        run_op("logic_and", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0001, 1'b1, 1'b1,
               exp_t'{f: 32'hF000_F000, c: 1'b0, v: 1'b0, e: 1'b0});

        // Start during RUN must be ignored
        @(negedge clk);
        drive(32'h1234_5678, 32'h1111_1111, ULA_ADD, 1'b0, 1'b0);
        sb_q.push_back(exp_t'{f: 32'h2345_6789, c: 1'b0, v: 1'b0, e: 1'b0});
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        drive(32'hFFFF_0000, 32'h0000_FFFF, ULA_SUB, 1'b0, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("ignored_start");
        repeat (4) @(negedge clk);
        check("ignored_start_busy", W'(bus.busy), '0);

        // Reset mid-operation: no done, outputs cleared
        @(negedge clk);
        drive(32'h0000_0001, 32'h0000_0001, ULA_ADD, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", W'(bus.busy), '0);
        check("abort_f", bus.f, '0);
        check("abort_flags", W'({bus.c_out, bus.overflow, bus.a_eq_b}), '0);
        repeat (8) @(negedge clk);
        check("abort_no_done_busy", W'(bus.busy), '0);

        // Start coincident with reset is ignored
        @(negedge clk);
        rst = 1'b1;
        drive(32'h0000_0003, 32'h0000_0004, ULA_ADD, 1'b0, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", W'(bus.busy), '0);
        @(negedge clk);
        check("rst_start_busy2", W'(bus.busy), '0);

        run_op("post_reset", 32'h0102_0304, 32'h1010_1010, ULA_ADD, 1'b0, 1'b0,
               exp_t'{f: 32'h1112_1314, c: 1'b0, v: 1'b0, e: 1'b0});

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
